// File: rtl/exc_commit_ctrl_pkg.sv
// Package: exc_commit_ctrl_pkg
// Shared types and constants for the exception/interrupt/ertn commit sequencer.
//   state_t : commit FSM states (IDLE, COMMIT, FLUSH, REDIRECT)
//   cause_t : latched cause of the committing event
//   ECODE_* : exception codes this block produces or tests against
package exc_commit_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_INT  = 2'd1,
    CAUSE_EX   = 2'd2,
    CAUSE_ERTN = 2'd3
  } cause_t;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_SYS = 6'h0B;

endpackage

// File: rtl/exc_prio_sel.sv
// Module: exc_prio_sel
// Combinational priority selector for the event carried by the WB instruction.
// Priority is interrupt > synchronous exception > ertn; an empty WB slot
// never produces an event.
// Ports:
//   ws_valid, has_int, ws_ex, ws_ertn : event sources
//   ws_ecode, ws_esubcode             : code/subcode of a synchronous exception
//   evt                               : an event is present this cycle
//   cause                             : winning cause (CAUSE_NONE when no event)
//   ecode, esubcode                   : code/subcode to commit (0 for ertn)
module exc_prio_sel
  import exc_commit_ctrl_pkg::*;
(
  input  logic       ws_valid,
  input  logic       has_int,
  input  logic       ws_ex,
  input  logic [5:0] ws_ecode,
  input  logic [8:0] ws_esubcode,
  input  logic       ws_ertn,
  output logic       evt,
  output cause_t     cause,
  output logic [5:0] ecode,
  output logic [8:0] esubcode
);

  always_comb begin
    evt      = 1'b0;
    cause    = CAUSE_NONE;
    ecode    = 6'h00;
    esubcode = 9'h000;
    if (ws_valid) begin
      if (has_int) begin
        evt   = 1'b1;
        cause = CAUSE_INT;
        ecode = ECODE_INT;
      end else if (ws_ex) begin
        evt      = 1'b1;
        cause    = CAUSE_EX;
        ecode    = ws_ecode;
        esubcode = ws_esubcode;
      end else if (ws_ertn) begin
        evt   = 1'b1;
        cause = CAUSE_ERTN;
      end
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Module: exc_commit_ctrl
// Sequences exception / interrupt / ertn commit at the writeback boundary:
// one-cycle CSR commit pulse, a pipeline flush held for 1+FLUSH_CYCLES cycles,
// then a redirect PC offered to fetch.
// Optional build macro: EXC_CNT_EN adds exc_cnt / ertn_cnt commit counters.
// Parameters:
//   FLUSH_CYCLES : cycles pipe_flush stays high after the commit cycle (1..15)
// Ports:
//   clk, resetn                    : clock, asynchronous active-low reset
//   ws_valid/ws_ex/ws_ecode/ws_esubcode/ws_ertn/ws_pc : WB instruction event info
//   has_int                        : enabled pending interrupt from CSR
//   csr_eentry, csr_era            : redirect targets for int/ex and ertn
//   redirect_ready                 : fetch accepts the redirect
//   ws_stall                       : hold WB
//   wb_ex/wb_ecode/wb_esubcode/wb_pc : CSR exception commit (COMMIT cycle only)
//   eret_flush                     : CSR ertn commit (COMMIT cycle only)
//   pipe_flush                     : kill IF..MEM
//   redirect_valid, redirect_pc    : redirect to fetch
//   busy                           : sequencer not idle
//   exc_cnt, ertn_cnt              : commit counters (EXC_CNT_EN only)
//
// Redirect handshake: redirect_valid rises when the flush completes and, with
// redirect_pc, stays stable until a cycle where redirect_valid & redirect_ready
// are both high; that cycle is the transfer and the block returns to IDLE.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic        ws_ertn,
  input  logic [31:0] ws_pc,
  input  logic        has_int,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        redirect_ready,
  output logic        ws_stall,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        eret_flush,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
`ifdef EXC_CNT_EN
  ,
  output logic [31:0] exc_cnt,
  output logic [31:0] ertn_cnt
`endif
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  cause_t      cause_q;
  logic [5:0]  ecode_q;
  logic [8:0]  esub_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic [3:0]  cnt_q;

  logic        evt;
  cause_t      sel_cause;
  logic [5:0]  sel_ecode;
  logic [8:0]  sel_esub;

  exc_prio_sel u_prio (
    .ws_valid    (ws_valid),
    .has_int     (has_int),
    .ws_ex       (ws_ex),
    .ws_ecode    (ws_ecode),
    .ws_esubcode (ws_esubcode),
    .ws_ertn     (ws_ertn),
    .evt         (evt),
    .cause       (sel_cause),
    .ecode       (sel_ecode),
    .esubcode    (sel_esub)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (evt) state_d = COMMIT;
      COMMIT:   state_d = FLUSH;
      FLUSH:    if (cnt_q == 4'd0) state_d = REDIRECT;
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Event info is captured only on acceptance in IDLE; later WB contents are
  // ignored because the flush invalidates them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cause_q  <= CAUSE_NONE;
      ecode_q  <= 6'h00;
      esub_q   <= 9'h000;
      pc_q     <= 32'h0;
      target_q <= 32'h0;
      cnt_q    <= 4'd0;
    end else begin
      if (state_q == IDLE && evt) begin
        cause_q <= sel_cause;
        ecode_q <= sel_ecode;
        esub_q  <= sel_esub;
        pc_q    <= ws_pc;
      end
      // Target sampled in COMMIT so the CSR values reflect any update made
      // alongside the commit pulse's own cycle.
      if (state_q == COMMIT) begin
        target_q <= (cause_q == CAUSE_ERTN) ? csr_era : csr_eentry;
        cnt_q    <= FLUSH_INIT;
      end else if (state_q == FLUSH && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

`ifdef EXC_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_cnt  <= 32'h0;
      ertn_cnt <= 32'h0;
    end else if (state_q == COMMIT) begin
      if (cause_q == CAUSE_ERTN) ertn_cnt <= ertn_cnt + 32'd1;
      else                       exc_cnt  <= exc_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    wb_ex          = 1'b0;
    eret_flush     = 1'b0;
    wb_ecode       = 6'h00;
    wb_esubcode    = 9'h000;
    wb_pc          = 32'h0;
    pipe_flush     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    busy           = (state_q != IDLE);
    // resetn gates the stall so every output is 0 while reset is asserted.
    ws_stall       = resetn & ((state_q != IDLE) | evt);
    case (state_q)
      COMMIT: begin
        wb_ex       = (cause_q != CAUSE_ERTN);
        eret_flush  = (cause_q == CAUSE_ERTN);
        wb_ecode    = ecode_q;
        wb_esubcode = esub_q;
        wb_pc       = pc_q;
        pipe_flush  = 1'b1;
      end
      FLUSH: pipe_flush = 1'b1;
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Testbench: tb_exc_commit_ctrl
// Drives directed and random WB events into exc_commit_ctrl and compares every
// output each cycle against a timeline model: an accepted event at cycle T
// commits at T+1, flushes through T+1+FC and offers the redirect from T+2+FC
// until the handshake. Redirect targets are kept in an expected queue.
module tb_exc_commit_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid, ws_ex, ws_ertn, has_int, redirect_ready;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic [31:0] ws_pc, csr_eentry, csr_era;
  logic        ws_stall, wb_ex, eret_flush, pipe_flush, redirect_valid, busy;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, redirect_pc;
`ifdef EXC_CNT_EN
  logic [31:0] exc_cnt, ertn_cnt;
`endif

  // next-cycle input values, applied by tick()
  logic        nx_valid, nx_ex, nx_ertn, nx_int, nx_rdy;
  logic [5:0]  nx_ecode;
  logic [8:0]  nx_esub;
  logic [31:0] nx_pc, nx_eentry, nx_era;

  // reference model state
  bit          m_busy;
  int          m_age;     // cycles since the accepted event
  int          m_kind;    // 0 interrupt, 1 exception, 2 ertn
  logic [5:0]  m_ecode;
  logic [8:0]  m_esub;
  logic [31:0] m_pc;
  logic [31:0] m_exc_cnt, m_ertn_cnt;
  logic [31:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exc_commit_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_valid       (ws_valid),
    .ws_ex          (ws_ex),
    .ws_ecode       (ws_ecode),
    .ws_esubcode    (ws_esubcode),
    .ws_ertn        (ws_ertn),
    .ws_pc          (ws_pc),
    .has_int        (has_int),
    .csr_eentry     (csr_eentry),
    .csr_era        (csr_era),
    .redirect_ready (redirect_ready),
    .ws_stall       (ws_stall),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_pc          (wb_pc),
    .eret_flush     (eret_flush),
    .pipe_flush     (pipe_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
`ifdef EXC_CNT_EN
    ,
    .exc_cnt        (exc_cnt),
    .ertn_cnt       (ertn_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy     = 1'b0;
    m_age      = 0;
    m_kind     = 0;
    m_ecode    = '0;
    m_esub     = '0;
    m_pc       = '0;
    m_exc_cnt  = '0;
    m_ertn_cnt = '0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_step();
    if (!m_busy) begin
      if (ws_valid && (has_int || ws_ex || ws_ertn)) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_pc   = ws_pc;
        if (has_int) begin
          m_kind = 0; m_ecode = 6'h00; m_esub = 9'h000;
        end else if (ws_ex) begin
          m_kind = 1; m_ecode = ws_ecode; m_esub = ws_esubcode;
        end else begin
          m_kind = 2; m_ecode = 6'h00; m_esub = 9'h000;
        end
      end
    end else if (m_age >= 2 + FC) begin
      if (redirect_ready) begin
        m_busy = 1'b0;
        void'(exp_q.pop_front());
      end
    end else begin
      if (m_age == 1) begin
        exp_q.push_back(m_kind == 2 ? csr_era : csr_eentry);
        if (m_kind == 2) m_ertn_cnt = m_ertn_cnt + 32'd1;
        else             m_exc_cnt  = m_exc_cnt + 32'd1;
      end
      m_age++;
    end
  endtask

  task automatic check_all();
    bit evt, commit, flush, redir;
    logic [31:0] exp_rpc;
    evt    = ws_valid && (has_int || ws_ex || ws_ertn);
    commit = m_busy && (m_age == 1);
    flush  = m_busy && (m_age <= 1 + FC);
    redir  = m_busy && (m_age >= 2 + FC);
    exp_rpc = (redir && exp_q.size() > 0) ? exp_q[0] : 32'h0;
    check_eq("ws_stall",   ws_stall,   m_busy ? 1 : evt);
    check_eq("busy",       busy,       m_busy);
    check_eq("pipe_flush", pipe_flush, flush);
    check_eq("wb_ex",      wb_ex,      commit && m_kind != 2);
    check_eq("eret_flush", eret_flush, commit && m_kind == 2);
    check_eq("wb_pc",      wb_pc,      commit ? m_pc : 32'h0);
    if (!(commit && m_kind == 2)) begin
      check_eq("wb_ecode",    wb_ecode,    commit ? m_ecode : 6'h00);
      check_eq("wb_esubcode", wb_esubcode, commit ? m_esub : 9'h000);
    end
    check_eq("redirect_valid", redirect_valid, redir);
    check_eq("redirect_pc",    redirect_pc,    exp_rpc);
`ifdef EXC_CNT_EN
    check_eq("exc_cnt",  exc_cnt,  m_exc_cnt);
    check_eq("ertn_cnt", ertn_cnt, m_ertn_cnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    ws_valid       = nx_valid;
    ws_ex          = nx_ex;
    ws_ertn        = nx_ertn;
    has_int        = nx_int;
    redirect_ready = nx_rdy;
    ws_ecode       = nx_ecode;
    ws_esubcode    = nx_esub;
    ws_pc          = nx_pc;
    csr_eentry     = nx_eentry;
    csr_era        = nx_era;
    @(negedge clk);
    check_all();
  endtask

  task automatic set_idle();
    nx_valid = 1'b0; nx_ex = 1'b0; nx_ertn = 1'b0; nx_int = 1'b0; nx_rdy = 1'b0;
  endtask

  task automatic rand_inputs();
    nx_valid  = ($urandom_range(0, 99) < 50);
    nx_int    = ($urandom_range(0, 99) < 10);
    nx_ex     = ($urandom_range(0, 99) < 30);
    nx_ertn   = ($urandom_range(0, 99) < 20);
    nx_rdy    = ($urandom_range(0, 99) < 40);
    nx_ecode  = 6'($urandom);
    nx_esub   = 9'($urandom);
    nx_pc     = $urandom;
    nx_eentry = $urandom;
    nx_era    = $urandom;
  endtask

  initial begin
    resetn = 1'b0;
    ws_valid = 1'b0; ws_ex = 1'b0; ws_ertn = 1'b0; has_int = 1'b0; redirect_ready = 1'b0;
    ws_ecode = '0; ws_esubcode = '0; ws_pc = '0; csr_eentry = '0; csr_era = '0;
    set_idle();
    nx_ecode = '0; nx_esub = '0; nx_pc = '0; nx_eentry = '0; nx_era = '0;
    model_reset();

    // reset state
    #2;
    check_all();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // syscall with FC=2: commit at T+1, flush T+1..T+3, redirect at T+4
    nx_eentry = 32'h1c008000; nx_era = 32'h1c000204;
    nx_valid = 1'b1; nx_ex = 1'b1; nx_ecode = 6'h0B; nx_esub = 9'h000; nx_pc = 32'h1c000100;
    tick();
    check_eq("sys_stall_T", ws_stall, 1);
    set_idle();
    tick();
    check_eq("sys_wb_ex_T1", wb_ex, 1);
    check_eq("sys_ecode_T1", wb_ecode, 6'h0B);
    check_eq("sys_pc_T1", wb_pc, 32'h1c000100);
    tick();
    check_eq("sys_wb_ex_T2", wb_ex, 0);
    check_eq("sys_flush_T2", pipe_flush, 1);
    tick();
    check_eq("sys_flush_T3", pipe_flush, 1);
    check_eq("sys_rv_T3", redirect_valid, 0);
    tick();
    check_eq("sys_rv_T4", redirect_valid, 1);
    check_eq("sys_rpc_T4", redirect_pc, 32'h1c008000);
    check_eq("sys_flush_T4", pipe_flush, 0);
    // ready held low: everything stays put
    repeat (5) begin
      tick();
      check_eq("hold_rv", redirect_valid, 1);
      check_eq("hold_rpc", redirect_pc, 32'h1c008000);
      check_eq("hold_stall", ws_stall, 1);
      check_eq("hold_busy", busy, 1);
    end
    nx_rdy = 1'b1;
    tick();
    set_idle();
    tick();
    check_eq("hs_busy_after", busy, 0);

    // ertn
    nx_valid = 1'b1; nx_ertn = 1'b1; nx_pc = 32'h1c000300;
    tick();
    set_idle();
    tick();
    check_eq("ertn_pulse", eret_flush, 1);
    check_eq("ertn_no_wb_ex", wb_ex, 0);
    repeat (FC + 1) tick();
    check_eq("ertn_rpc", redirect_pc, 32'h1c000204);
    nx_rdy = 1'b1;
    tick();
    set_idle();
    tick();

    // interrupt wins over exception and ertn
    nx_valid = 1'b1; nx_int = 1'b1; nx_ex = 1'b1; nx_ertn = 1'b1; nx_ecode = 6'h0B; nx_esub = 9'h1A5;
    tick();
    set_idle();
    tick();
    check_eq("int_wb_ex", wb_ex, 1);
    check_eq("int_ecode", wb_ecode, 6'h00);
    check_eq("int_esub", wb_esubcode, 9'h000);
    check_eq("int_no_eret", eret_flush, 0);
    nx_rdy = 1'b1;
    repeat (FC + 2) tick();
    set_idle();
    tick();

    // reset asserted mid-flush takes effect without a clock edge
    nx_valid = 1'b1; nx_ex = 1'b1; nx_ecode = 6'h0B; nx_pc = 32'h1c000400;
    tick();
    set_idle();
    tick();
    tick();
    #1;
    resetn = 1'b0;
    ws_valid = 1'b1; ws_ex = 1'b1;
    #1;
    check_eq("rst_pipe_flush", pipe_flush, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ws_stall", ws_stall, 0);
    check_eq("rst_redirect_valid", redirect_valid, 0);
    check_eq("rst_wb_ex", wb_ex, 0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    ws_valid = 1'b0; ws_ex = 1'b0;
    set_idle();
    tick();
    // new syscall after reset
    nx_valid = 1'b1; nx_ex = 1'b1; nx_ecode = 6'h0B; nx_pc = 32'h1c000500; nx_eentry = 32'h1c008000;
    tick();
    set_idle();
    tick();
    check_eq("post_rst_wb_ex", wb_ex, 1);
    check_eq("post_rst_pc", wb_pc, 32'h1c000500);
    repeat (FC + 1) tick();
    check_eq("post_rst_rpc", redirect_pc, 32'h1c008000);
    nx_rdy = 1'b1;
    tick();
    set_idle();
    tick();

    // random traffic, including events while busy and back-to-back events
    repeat (800) begin
      rand_inputs();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Sequences exception, interrupt and ertn commit at the writeback boundary.
- Takes the event candidate carried by the WB instruction and arbitrates between interrupt, exception and ertn.
- Drives a single-cycle CSR commit pulse, holds a multi-cycle pipeline flush, then hands a redirect PC to the fetch stage with a valid/ready handshake.
- Sits between wb_stage, the csr unit and if_stage; replaces the ad-hoc combinational flush path.

Parameters:
- FLUSH_CYCLES, 2: number of cycles pipe_flush stays high after the commit cycle; legal range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ws_valid  in  1  WB holds a valid instruction
- ws_ex  in  1  WB instruction raised a synchronous exception
- ws_ecode  in  6  exception code of ws_ex
- ws_esubcode  in  9  exception subcode of ws_ex
- ws_ertn  in  1  WB instruction is ertn
- ws_pc  in  32  PC of WB instruction
- has_int  in  1  CSR reports an enabled pending interrupt
- csr_eentry  in  32  current EENTRY value
- csr_era  in  32  current ERA value
- redirect_ready  in  1  fetch accepts the redirect
- ws_stall  out  1  hold WB (forces ws_ready_go low)
- wb_ex  out  1  CSR exception-commit pulse
- wb_ecode  out  6  code for the CSR
- wb_esubcode  out  9  subcode for the CSR
- wb_pc  out  32  PC written to ERA
- eret_flush  out  1  CSR ertn-commit pulse
- pipe_flush  out  1  kill all stages IF..MEM
- redirect_valid  out  1  redirect target valid
- redirect_pc  out  32  redirect target
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: clk and resetn as stated in Already decided. While resetn is low, FSM = IDLE and every output and internal register is 0, independent of clk.
- Event detection (IDLE only): event = ws_valid & (has_int | ws_ex | ws_ertn).
  - Priority: has_int > ws_ex > ws_ertn.
  - Interrupt: ecode = ECODE_INT (0x00), esubcode = 0.
- ws_stall: combinational, = event in IDLE, and 1 in every other state.
- IDLE → COMMIT when event. On that edge, latch the cause (int/ex/ertn), ecode, esubcode and ws_pc.
- COMMIT (exactly 1 cycle):
  - Pulse wb_ex = 1 for int/ex, or eret_flush = 1 for ertn. Never both.
  - wb_ecode, wb_esubcode and wb_pc show the latched values; they are 0 in all other states.
  - pipe_flush = 1.
  - Latch the target: csr_eentry for int/ex, csr_era for ertn.
  - Next state: FLUSH with count = FLUSH_CYCLES-1.
- FLUSH: pipe_flush = 1. Count decrements each cycle; at 0 → REDIRECT.
  - pipe_flush is therefore high for exactly 1 + FLUSH_CYCLES cycles.
- REDIRECT:
  - redirect_valid = 1; redirect_pc = latched target, held stable until the handshake.
  - pipe_flush = 0.
  - On redirect_valid & redirect_ready → IDLE; redirect_valid drops the next cycle.
- Latency: event cycle T gives commit pulse at T+1 and redirect_valid first at T+2+FLUSH_CYCLES.
- busy = (state != IDLE).
- Events presented while busy are ignored; the flush has invalidated them.
- Exceptions on a non-valid WB slot (ws_valid=0) are ignored.
- A back-to-back event in the cycle after returning to IDLE is accepted normally.
- redirect_pc is 0 outside REDIRECT.

Optional Feature:
- Macro EXC_CNT_EN.
- Defined:
  - Adds outputs exc_cnt[31:0] and ertn_cnt[31:0].
  - Each increments by 1 in the COMMIT cycle of an int/ex or ertn commit respectively.
  - Both wrap modulo 2^32 and reset to 0 asynchronously.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header/package entries:
  - FSM state encodings IDLE/COMMIT/FLUSH/REDIRECT
  - ECODE_INT = 6'h00 and ECODE_SYS = 6'h0B
  - Cause encoding (CAUSE_INT/CAUSE_EX/CAUSE_ERTN)
- One sub-module, exc_prio_sel: the combinational priority selector producing event, cause, ecode and esubcode.
- The FSM, flush counter and latches stay in the top module.

Test Plan:
- Syscall (FLUSH_CYCLES=2): event at T with ws_ex=1, ecode=0x0B, ws_pc=0x1c000100, eentry=0x1c008000.
  → wb_ex=1 at T+1 only, with wb_ecode=0x0B and wb_pc=0x1c000100; pipe_flush high T+1..T+3; redirect_valid at T+4 with redirect_pc=0x1c008000.
- ertn with era=0x1c000204 → eret_flush pulse at T+1, wb_ex stays 0, redirect_pc=0x1c000204.
- has_int, ws_ex (ecode 0x0B) and ws_ertn all high at once → wb_ex pulse with wb_ecode=0x00, eret_flush=0.
- redirect_ready held low 5 cycles in REDIRECT → redirect_valid, redirect_pc, ws_stall and busy all stable; ready=1 → busy=0 next cycle.
- resetn pulled low mid-FLUSH → pipe_flush, busy and ws_stall 0 immediately (before the next clk edge); after release, a new syscall completes normally.
- With EXC_CNT_EN: 3 syscalls and 1 ertn, plus an event injected while busy → exc_cnt=3 and ertn_cnt=1; the busy-time event produces no commit pulse.
